// File: rtl/bin2bcd_seq_if.sv
// Start/Busy/Done handshake and data bus between the ALU result stage and the
// binary-to-BCD converter.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  Start;
  logic [WIDTH-1:0]      Bin;
  logic                  Busy;
  logic                  Done;
  logic [4*DIGITS-1:0]   Bcd;

  modport master (output Start, Bin, input Busy, Done, Bcd);
  modport slave  (input Start, Bin, output Busy, Done, Bcd);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Bcd only updates on completion; Done pulses in the cycle the new value appears.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic            Clock,
  input  logic            Reset,
  bin2bcd_seq_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               done_q, done_d;
  logic [BCD_W+WIDTH-1:0] cat;

  // Per-digit correction; digits are independent, no carry between them.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] w);
    logic [BCD_W-1:0] r;
    r = w;
    for (int i = 0; i < DIGITS; i++) begin
      if (w[4*i +: 4] >= 4'd5) r[4*i +: 4] = w[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    cat     = {add3(work_q), shift_q} << 1;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          shift_d = bus.Bin;
          work_d  = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d  = cat[BCD_W+WIDTH-1 -: BCD_W];
        shift_d = cat[WIDTH-1:0];
        cnt_d   = cnt_q - CNT_W'(1);
        // Last bit shifted in: publish the post-shift digits directly.
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = cat[BCD_W+WIDTH-1 -: BCD_W];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Busy = (state_q == SHIFT);
  assign bus.Done = done_q;
  assign bus.Bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: vector table, handshake corner cases and a
// full 8-bit sweep against an arithmetic decimal reference.
module tb_bin2bcd_seq;

  logic Clock = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  bin2bcd_seq_if #(.WIDTH(8), .DIGITS(3)) bus ();

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  // Single conversion from idle; Bin is scrambled right after acceptance.
  task automatic run_conv(input logic [7:0] v, input logic [11:0] exp, input string tag);
    int   lat;
    logic busy_ok;
    bus.Bin   = v;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    bus.Bin   = ~v;
    lat     = 0;
    busy_ok = 1'b1;
    while (!bus.Done && lat < 20) begin
      if (!bus.Busy) busy_ok = 1'b0;
      step();
      lat++;
    end
    check($sformatf("%s latency", tag), lat, 8);
    check($sformatf("%s busy_during", tag), busy_ok, 1);
    check($sformatf("%s bcd", tag), bus.Bcd, exp);
    check($sformatf("%s busy_at_done", tag), bus.Busy, 0);
    step();
    check($sformatf("%s done_drop", tag), bus.Done, 0);
  endtask

  initial begin
    int   dcount;
    logic quiet;

    vecs[0] = '{8'd0,   12'h000};
    vecs[1] = '{8'd255, 12'h255};
    vecs[2] = '{8'd128, 12'h128};
    vecs[3] = '{8'd7,   12'h007};
    vecs[4] = '{8'd9,   12'h009};
    vecs[5] = '{8'd10,  12'h010};
    vecs[6] = '{8'd99,  12'h099};
    vecs[7] = '{8'd100, 12'h100};
    vecs[8] = '{8'd199, 12'h199};
    vecs[9] = '{8'd64,  12'h064};

    bus.Start = 1'b0;
    bus.Bin   = 8'd0;
    Reset     = 1'b1;
    step();
    step();
    check("reset busy", bus.Busy, 0);
    check("reset done", bus.Done, 0);
    check("reset bcd",  bus.Bcd, 12'h000);
    Reset = 1'b0;
    step();

    for (int i = 0; i < 10; i++)
      run_conv(vecs[i].bin, vecs[i].bcd, $sformatf("vec%0d", i));

    // Back-to-back: Start held through the Done cycle.
    bus.Bin   = 8'd128;
    bus.Start = 1'b1;
    step();
    bus.Bin = 8'd7;
    repeat (8) step();
    check("b2b first done", bus.Done, 1);
    check("b2b first bcd",  bus.Bcd, 12'h128);
    step();
    bus.Start = 1'b0;
    check("b2b done drop", bus.Done, 0);
    check("b2b busy again", bus.Busy, 1);
    repeat (8) step();
    check("b2b second done", bus.Done, 1);
    check("b2b second bcd",  bus.Bcd, 12'h007);
    step();

    // Start while busy is ignored; Bin changes after acceptance are ignored.
    bus.Bin   = 8'd99;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    step();
    step();
    bus.Start = 1'b1;
    bus.Bin   = 8'd42;
    step();
    bus.Start = 1'b0;
    bus.Bin   = 8'd200;
    step();
    dcount = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.Done) begin
        dcount++;
        check("ignore bcd", bus.Bcd, 12'h099);
      end
      step();
    end
    check("ignore done count", dcount, 1);

    // Reset mid-conversion: abandoned, no Done, Bcd cleared.
    bus.Bin   = 8'd173;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    repeat (3) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("abort busy", bus.Busy, 0);
    check("abort bcd",  bus.Bcd, 12'h000);
    quiet = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (bus.Done || bus.Busy || bus.Bcd != 12'h000) quiet = 1'b0;
      step();
    end
    check("abort quiet", quiet, 1);

    for (int v = 0; v < 256; v++)
      run_conv(8'(v), ref_bcd(v), $sformatf("sweep%0d", v));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It sits directly downstream of the ALU result register. It takes the registered 8-bit ALU result and produces three BCD digits for the seven-segment hex decoders, so results display in decimal. A Start/Busy/Done handshake lets the ALU stage trigger a conversion each time its register updates.

Parameters:
WIDTH, 8, bit width of the binary input.
DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1; other values are unsupported.

Ports:
Clock  input  1  rising-edge clock for all state.
Reset  input  1  synchronous, active-high reset; sampled on the rising edge of Clock.
Start  input  1  request a conversion of Bin; sampled on the rising edge; acted on only when idle.
Bin  input  WIDTH  binary value to convert; sampled only on the accepting edge.
Busy  output  1  high while a conversion is in progress.
Done  output  1  one-cycle pulse marking the cycle in which Bcd first holds the new result.
Bcd  output  4*DIGITS  packed result, digit 0 (units) in bits [3:0]; held until the next completion.

Behaviour:
- Reset (Reset=1 at an edge) has priority over everything else:
  - state returns to IDLE; Busy=0, Done=0, Bcd=0; internal working and counter registers cleared.
  - A conversion in progress is abandoned. No Done pulse is issued for it, and Bcd stays 0.
- States:
  - IDLE: waiting.
  - SHIFT: converting.
- IDLE, Start=1 at edge E0:
  - load the shift register with Bin and clear the BCD work register.
  - load the bit counter with WIDTH; set Busy=1; go to SHIFT.
- IDLE, Start=0: remain in IDLE. Done is cleared one cycle after it pulses.
- SHIFT, each edge:
  - every 4-bit work digit >= 5 gets +3 (no carry between digits);
  - then shift {work, shift register} left by 1, so the MSB of Bin enters digit 0 LSB;
  - decrement the counter.
- Final shift (counter == 1) at edge E_WIDTH:
  - write the post-shift work register to Bcd; set Done=1 and Busy=0; return to IDLE.
- Latency: Start accepted at E0 gives the result on Bcd with Done=1 in the cycle after edge E_WIDTH (8 clocks at the defaults).
- Start while Busy=1 is ignored; it is not queued.
- Start=1 in the Done cycle (state is IDLE) is accepted, giving back-to-back conversions with no gap. Done then drops on the next edge.
- Changes to Bin after the accepting edge do not affect the conversion in progress.
- Bcd changes only on a completion edge or on reset. Intermediate work values are never visible on Bcd.
- Digit arithmetic is 4 bits wide; the add-3 step never overflows a digit within the supported parameter range.
- Counter width is clog2(WIDTH)+1 bits.

Test Plan:
1. Reset 2 cycles, then Start with Bin=8'd0 -> Busy high for 8 cycles, then Done pulse with Bcd=12'h000.
2. Bin=8'd255, Start pulsed at E0 -> Done=1 exactly in the cycle after E8, Bcd=12'h255, Busy=0 in the same cycle; Done low one cycle later.
3. Bin=8'd128 then, with Start held high through its Done cycle, Bin=8'd7 -> first Done with Bcd=12'h128, second Done 8 cycles later with Bcd=12'h007.
4. Start Bin=8'd99, pulse Start again with Bin=8'd42 at E3, and change Bin to 8'd200 at E4 -> single Done with Bcd=12'h099; no second conversion.
5. Start Bin=8'd173, assert Reset at E4 -> Busy=0, Bcd=12'h000 from E4 onward; no Done pulse in the following 10 cycles.
6. Sweep all 256 Bin values against a behavioural reference -> each Bcd equals {hundreds, tens, units} of Bin, each with latency 8.
